// File: rtl/neuron_accum_q17_14.sv
// -----------------------------------------------------------------------------
// neuron_accum_q17_14
//
// Accumulates N_INPUTS signed Q17.14 weight x pixel products for one neuron,
// adds the neuron bias, saturates the result to DATA_W bits and hands it to
// the next layer over a valid/ready handshake.
//
// Frame flow:  IDLE -> ACCUM (N_INPUTS-1 more beats) -> BIAS -> DONE -> IDLE
//   IDLE  : first product of a frame loads the accumulator.
//   ACCUM : remaining products are added; bubbles on prod_valid just hold.
//   BIAS  : bias added, sum saturated and registered into out_data.
//   DONE  : result held until the downstream handshake, then clear.
//
// The accumulator carries GUARD_W extra MSBs so that N_INPUTS full-scale
// products plus a full-scale bias can never wrap; saturation is therefore a
// simple check of the bits above the DATA_W sign bit.
//
// Optional build macro:
//   NEURON_RELU_EN - a negative saturated result is replaced by zero (ReLU).
//                    sat_flag still reports clipping of the pre-ReLU sum.
//                    Latency and throughput are identical in both builds.
// -----------------------------------------------------------------------------
module neuron_accum_q17_14 #(
   parameter int DATA_W   = 32,
   parameter int N_INPUTS = 784,
   parameter int GUARD_W  = $clog2(N_INPUTS + 1) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] prod_in,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [DATA_W-1:0] bias_in,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              sat_flag
);

   localparam int ACC_W = DATA_W + GUARD_W;
   localparam int CNT_W = $clog2(N_INPUTS + 1);

   // Count value held while the last product of the frame is being accepted.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

   // Saturation limits of a DATA_W two's-complement word.
   localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_BIAS,
      S_DONE
   } state_t;

   state_t                   state;
   logic signed [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]         cnt;

   logic                     beat;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  sum;
   logic [GUARD_W:0]         sum_top;
   logic                     clip;
   logic [DATA_W-1:0]        sat_data;
   logic [DATA_W-1:0]        result;

   // A product beat transfers only when both sides agree in the same cycle.
   assign beat = prod_valid & prod_ready;

   // Sign extension, bias addition, saturation and optional ReLU.
   always_comb begin
      // NOTE: every output of this block is given a value on every path,
      // starting with these defaults, so no latch can be inferred.
      prod_ext = '0;
      bias_ext = '0;
      sum      = '0;
      sum_top  = '0;
      clip     = 1'b0;
      sat_data = '0;
      result   = '0;

      prod_ext = {{GUARD_W{prod_in[DATA_W-1]}}, prod_in};
      bias_ext = {{GUARD_W{bias_in[DATA_W-1]}}, bias_in};
      sum      = acc + bias_ext;

      // The sum fits in DATA_W bits exactly when every bit from the DATA_W
      // sign position upwards agrees; anything else is out of range.
      sum_top  = sum[ACC_W-1:DATA_W-1];
      clip     = !((&sum_top) || !(|sum_top));

      if (!clip) begin
         sat_data = sum[DATA_W-1:0];
      end else if (sum[ACC_W-1]) begin
         sat_data = SAT_MIN;
      end else begin
         sat_data = SAT_MAX;
      end

`ifdef NEURON_RELU_EN
      result = sat_data[DATA_W-1] ? '0 : sat_data;
`else
      result = sat_data;
`endif
   end

   // Frame control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         acc        <= '0;
         cnt        <= '0;
         prod_ready <= 1'b1;
         out_data   <= '0;
         out_valid  <= 1'b0;
         sat_flag   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // NOTE: state is updated with non-blocking assignments so that
               // every register samples the values from before this edge.
               if (beat) begin
                  acc <= prod_ext;
                  cnt <= CNT_W'(1);
                  if (N_INPUTS == 1) begin
                     prod_ready <= 1'b0;
                     state      <= S_BIAS;
                  end else begin
                     state      <= S_ACCUM;
                  end
               end
            end

            S_ACCUM: begin
               if (beat) begin
                  acc <= acc + prod_ext;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST_CNT) begin
                     prod_ready <= 1'b0;
                     state      <= S_BIAS;
                  end
               end
            end

            S_BIAS: begin
               out_data  <= result;
               sat_flag  <= clip;
               out_valid <= 1'b1;
               state     <= S_DONE;
            end

            S_DONE: begin
               if (out_ready) begin
                  out_valid  <= 1'b0;
                  acc        <= '0;
                  cnt        <= '0;
                  prod_ready <= 1'b1;
                  state      <= S_IDLE;
               end
            end

            default: begin
               state      <= S_IDLE;
               prod_ready <= 1'b1;
               out_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_accum_q17_14.sv
// -----------------------------------------------------------------------------
// tb_neuron_accum_q17_14
//
// Directed bench for neuron_accum_q17_14. Two instances are used: one with
// N_INPUTS=4 (most frames) and one with N_INPUTS=1. Every frame's expected
// result is computed by a small reference model when the frame is driven and
// pushed to a scoreboard queue; it is popped and compared when the DUT
// presents out_valid. Inputs change 1 time unit after the rising edge and
// outputs are sampled at that same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_neuron_accum_q17_14;

   localparam int DATA_W = 32;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   // Instance A: four products per frame.
   logic [DATA_W-1:0] a_prod_in, a_bias_in, a_out_data;
   logic              a_prod_valid, a_prod_ready, a_out_valid, a_out_ready, a_sat_flag;

   // Instance B: single product per frame.
   logic [DATA_W-1:0] b_prod_in, b_bias_in, b_out_data;
   logic              b_prod_valid, b_prod_ready, b_out_valid, b_out_ready, b_sat_flag;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   neuron_accum_q17_14 #(.DATA_W(DATA_W), .N_INPUTS(4)) u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .prod_in    (a_prod_in),
      .prod_valid (a_prod_valid),
      .prod_ready (a_prod_ready),
      .bias_in    (a_bias_in),
      .out_data   (a_out_data),
      .out_valid  (a_out_valid),
      .out_ready  (a_out_ready),
      .sat_flag   (a_sat_flag)
   );

   neuron_accum_q17_14 #(.DATA_W(DATA_W), .N_INPUTS(1)) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .prod_in    (b_prod_in),
      .prod_valid (b_prod_valid),
      .prod_ready (b_prod_ready),
      .bias_in    (b_bias_in),
      .out_data   (b_out_data),
      .out_valid  (b_out_valid),
      .out_ready  (b_out_ready),
      .sat_flag   (b_sat_flag)
   );

   // Hard stop in case a wait is ever left unbounded.
   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- helpers
   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference model: wide signed sum -> saturated (and optionally ReLU'd) word.
   function automatic exp_t model(input longint sum);
      exp_t e;
      logic [63:0] s;
      s = sum;
      if (sum > 64'sd2147483647) begin
         e.data = 32'h7FFF_FFFF;
         e.sat  = 1'b1;
      end else if (sum < -64'sd2147483648) begin
         e.data = 32'h8000_0000;
         e.sat  = 1'b1;
      end else begin
         e.data = s[31:0];
         e.sat  = 1'b0;
      end
`ifdef NEURON_RELU_EN
      if (e.data[31]) e.data = '0;
`endif
      return e;
   endfunction

   function automatic longint sx(input logic [DATA_W-1:0] v);
      return longint'(signed'(v));
   endfunction

   // Push the expected result of a four-product frame and present its bias.
   task automatic push_frame4(input logic [DATA_W-1:0] p0, p1, p2, p3, bias);
      sb_q.push_back(model(sx(p0) + sx(p1) + sx(p2) + sx(p3) + sx(bias)));
      a_bias_in = bias;
   endtask

   // Offer one product to instance sel; return #1 after the accepting edge.
   task automatic send(input bit sel, input logic [DATA_W-1:0] d);
      int   n;
      logic rdy;
      n = 0;
      if (sel) begin b_prod_in = d; b_prod_valid = 1'b1; end
      else     begin a_prod_in = d; a_prod_valid = 1'b1; end
      rdy = sel ? b_prod_ready : a_prod_ready;
      while (!rdy && n < 20) begin
         @(posedge clk); #1;
         n++;
         rdy = sel ? b_prod_ready : a_prod_ready;
      end
      check("beat_ready", {31'd0, rdy}, 32'd1);
      @(posedge clk); #1;
      if (sel) b_prod_valid = 1'b0;
      else     a_prod_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid, compare against the scoreboard, handshake.
   task automatic collect(input bit sel, input string tag, input int budget);
      int   n;
      logic vld;
      exp_t e;
      n = 0;
      vld = sel ? b_out_valid : a_out_valid;
      while (!vld && n < budget) begin
         @(posedge clk); #1;
         n++;
         vld = sel ? b_out_valid : a_out_valid;
      end
      check({tag, "_valid"}, {31'd0, vld}, 32'd1);
      check({tag, "_sb_nonempty"}, {31'd0, sb_q.size() > 0}, 32'd1);
      if (vld && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, "_data"}, sel ? b_out_data : a_out_data, e.data);
         check({tag, "_sat"}, {31'd0, sel ? b_sat_flag : a_sat_flag}, {31'd0, e.sat});
      end
      if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
      @(posedge clk); #1;
      if (sel) b_out_ready = 1'b0; else a_out_ready = 1'b0;
      check({tag, "_valid_clear"}, {31'd0, sel ? b_out_valid : a_out_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, sel ? b_prod_ready : a_prod_ready}, 32'd1);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      exp_t hold_e;

      rst          = 1'b1;
      a_prod_in    = '0; a_prod_valid = 1'b0; a_bias_in = '0; a_out_ready = 1'b0;
      b_prod_in    = '0; b_prod_valid = 1'b0; b_bias_in = '0; b_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state while reset is held.
      check("rst_out_valid",  {31'd0, a_out_valid},  32'd0);
      check("rst_prod_ready", {31'd0, a_prod_ready}, 32'd1);
      check("rst_out_data",   a_out_data,            32'd0);
      check("rst_sat_flag",   {31'd0, a_sat_flag},   32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Mixed-sign frame: 4.0 + 1.0 - 11.75 + 2.0 + 0.5 = -4.25.
      push_frame4(32'h0001_0000, 32'h0000_4000, 32'hFFFD_1000, 32'h0000_8000, 32'h0000_2000);
      send(1'b0, 32'h0001_0000);
      send(1'b0, 32'h0000_4000);
      send(1'b0, 32'hFFFD_1000);
      send(1'b0, 32'h0000_8000);
      check("mix_ready_low_bias", {31'd0, a_prod_ready}, 32'd0);
      collect(1'b0, "mix", 10);

      // Positive and negative saturation.
      push_frame4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0);
      for (int i = 0; i < 4; i++) send(1'b0, 32'h7FFF_FFFF);
      collect(1'b0, "sat_pos", 10);
      push_frame4(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0);
      for (int i = 0; i < 4; i++) send(1'b0, 32'h8000_0000);
      collect(1'b0, "sat_neg", 10);

      // Bubbles of 3 cycles between beats; exact output timing afterwards.
      // The accepting edge of the last beat moves the FSM to BIAS, the next
      // edge registers the result, so out_valid appears on the second edge
      // counting the accepting one.
      push_frame4(32'h0001_0000, 32'h0000_4000, 32'hFFFD_1000, 32'h0000_8000, 32'h0000_2000);
      send(1'b0, 32'h0001_0000);
      repeat (3) @(posedge clk);
      #1;
      check("bub_hold_ready", {31'd0, a_prod_ready}, 32'd1);
      send(1'b0, 32'h0000_4000);
      repeat (3) @(posedge clk);
      #1;
      check("bub_hold_valid", {31'd0, a_out_valid}, 32'd0);
      send(1'b0, 32'hFFFD_1000);
      repeat (3) @(posedge clk);
      #1;
      send(1'b0, 32'h0000_8000);
      check("bub_lat_edge1", {31'd0, a_out_valid}, 32'd0);
      @(posedge clk); #1;
      check("bub_lat_edge2", {31'd0, a_out_valid}, 32'd1);
      collect(1'b0, "bub", 0);

      // Backpressure: out_ready low for 5 cycles; output must stay put.
      push_frame4(32'h0001_0000, 32'h0000_4000, 32'hFFFD_1000, 32'h0000_8000, 32'h0000_2000);
      hold_e = sb_q[sb_q.size()-1];
      send(1'b0, 32'h0001_0000);
      send(1'b0, 32'h0000_4000);
      send(1'b0, 32'hFFFD_1000);
      send(1'b0, 32'h0000_8000);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         a_prod_valid = 1'b1;
         a_prod_in    = 32'h0000_4000;
         check("bp_valid",      {31'd0, a_out_valid},  32'd1);
         check("bp_data",       a_out_data,            hold_e.data);
         check("bp_sat",        {31'd0, a_sat_flag},   {31'd0, hold_e.sat});
         check("bp_prod_ready", {31'd0, a_prod_ready}, 32'd0);
         @(posedge clk); #1;
      end
      a_prod_valid = 1'b0;
      collect(1'b0, "bp", 0);
      push_frame4(32'h0000_4000, 32'h0000_4000, 32'h0000_4000, 32'h0000_4000, 32'h0);
      for (int i = 0; i < 4; i++) send(1'b0, 32'h0000_4000);
      collect(1'b0, "bp_next", 10);

      // Reset in the middle of a frame discards the partial sum.
      a_bias_in = 32'h0000_4000;
      send(1'b0, 32'h0001_0000);
      send(1'b0, 32'h0001_0000);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", {31'd0, a_out_valid},  32'd0);
      check("mid_rst_ready", {31'd0, a_prod_ready}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      push_frame4(32'h0000_4000, 32'h0000_4000, 32'h0000_4000, 32'h0000_4000, 32'h0000_4000);
      for (int i = 0; i < 4; i++) send(1'b0, 32'h0000_4000);
      collect(1'b0, "post_rst", 10);

      // Single-product neuron: 1.0 + (-1.0) = 0.
      b_bias_in = 32'hFFFF_C000;
      sb_q.push_back(model(sx(32'h0000_4000) + sx(32'hFFFF_C000)));
      send(1'b1, 32'h0000_4000);
      check("n1_ready_low", {31'd0, b_prod_ready}, 32'd0);
      collect(1'b1, "n1", 10);

      check("sb_drained", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
